rfile_dump: RTL



---
 rtl/rfile_dump.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rfile_dump.sv
// rfile_dump: read-side scanner for the 32x32 register file.
//
// On a start pulse it walks read addresses FIRST..31 through one
// register-file read port. It snapshots each word in its own READ cycle and
// streams the word out over a valid/ready handshake. It never writes the
// register file.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset (abandons any dump in flight)
//   start_i      dump request, sampled only in IDLE
//   busy_o       high in READ, SEND and DONE
//   done_o       one-cycle pulse after the last word has handshaken
//   rf_addr_o    registered read address toward the register file
//   rf_data_i    combinational read data for rf_addr_o
//   out_valid_o  output word valid
//   out_ready_i  consumer accepts the word
//   out_data_o   captured register value
//   out_idx_o    register index of out_data_o
module rfile_dump #(
    parameter int ADDRW   = 5,
    parameter int DATAW   = 32,
    parameter int SKIP_X0 = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ADDRW-1:0] rf_addr_o,
    input  logic [DATAW-1:0] rf_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DATAW-1:0] out_data_o,
    output logic [ADDRW-1:0] out_idx_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // x0 is skipped when SKIP_X0 is set; the all-ones index is terminal.
    localparam logic [ADDRW-1:0] FIRST_IDX = (SKIP_X0 != 0) ? ADDRW'(1'b1) : ADDRW'(1'b0);
    localparam logic [ADDRW-1:0] LAST_IDX  = {ADDRW{1'b1}};

    state_t             state_r;
    state_t             state_s;
    logic [ADDRW-1:0]   idx_r;
    logic [ADDRW-1:0]   idx_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;
    logic               valid_r;
    logic               valid_s;
    logic [DATAW-1:0]   data_r;
    logic [ADDRW-1:0]   oidx_r;
    logic               hs_s;

    assign hs_s        = valid_r & out_ready_i;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign out_valid_o = valid_r;
    assign out_data_o  = data_r;
    assign out_idx_o   = oidx_r;
    // idx_r is itself a register, so the read address is registered too.
    assign rf_addr_o   = idx_r;

    // State register plus registered flag outputs (decoded from next state).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            idx_r   <= ADDRW'(1'b0);
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            valid_r <= valid_s;
        end
    end

    // Next-state and scan-index logic.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_READ;
                    idx_s   = FIRST_IDX;
                end else begin
                    state_s = ST_IDLE;
                    idx_s   = idx_r;
                end
            end
            ST_READ: begin
                state_s = ST_SEND;
            end
            ST_SEND: begin
                if (hs_s) begin
                    if (idx_r == LAST_IDX) begin
                        // Terminal index: never wrap back to x0.
                        state_s = ST_DONE;
                        idx_s   = idx_r;
                    end else begin
                        state_s = ST_READ;
                        idx_s   = idx_r + ADDRW'(1'b1);
                    end
                end else begin
                    state_s = ST_SEND;
                    idx_s   = idx_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = ADDRW'(1'b0);
            end
        endcase
    end

    // Output decode of the next state; registered in the state register block.
    always_comb begin
        busy_s  = 1'b0;
        done_s  = 1'b0;
        valid_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_READ: begin
                busy_s = 1'b1;
            end
            ST_SEND: begin
                busy_s  = 1'b1;
                valid_s = 1'b1;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Snapshot of the read port at the end of each READ cycle; held through SEND.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_r <= DATAW'(1'b0);
            oidx_r <= ADDRW'(1'b0);
        end else if (state_r == ST_READ) begin
            data_r <= rf_data_i;
            oidx_r <= idx_r;
        end else begin
            data_r <= data_r;
            oidx_r <= oidx_r;
        end
    end

endmodule
